// File: rtl/xor_checksum_unit.sv
// xor_checksum_unit: sequential frame checksum engine.
// Accepts a frame of 1..MAX_WORDS words over a valid/ready handshake and folds
// each word into a 32-bit accumulator through one xor_32_bit instance. The
// final checksum and word count are then offered downstream on valid/ready.
//
// Optional feature macro: ROTATE_EN
//   defined   : the accumulator is rotated left by 1 before each XOR
//               (order-sensitive checksum)
//   undefined : plain XOR fold (order-insensitive checksum)
//
// Ports:
//   clk           in   clock, all state updates on posedge
//   rst_n         in   synchronous reset, active-low
//   start         in   frame start request, sampled only in IDLE
//   frame_len     in   words in the frame, sampled with start
//   in_valid      in   in_data is valid
//   in_data       in   input word
//   in_ready      out  word accepted when in_valid && in_ready
//   out_valid     out  checksum available
//   out_ready     in   consumer takes checksum when out_valid && out_ready
//   out_checksum  out  final checksum
//   out_count     out  number of words folded into out_checksum
//   busy          out  1 whenever the engine is not idle
//   err           out  1-cycle pulse for an illegal frame_len at start

// Pure 32-bit bitwise XOR.
module xor_32_bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  assign y = a ^ b;
endmodule

module xor_checksum_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_WORDS = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] frame_len,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_checksum,
  output logic [CNT_W-1:0] out_count,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_pre_c;
  logic [WIDTH-1:0] fold_c;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             len_ok_c;
  logic             in_hs_c;
  logic             out_hs_c;

  // Accumulator pre-conditioning ahead of the XOR fold.
`ifdef ROTATE_EN
  assign acc_pre_c = {acc[WIDTH-2:0], acc[WIDTH-1]};
`else
  assign acc_pre_c = acc;
`endif

  xor_32_bit u_xor (
    .a (acc_pre_c),
    .b (in_data),
    .y (fold_c)
  );

  assign cnt_inc_c = cnt + CNT_W'(1);
  assign len_ok_c  = (frame_len != '0) && (frame_len <= CNT_W'(MAX_WORDS));
  // in_ready is only ever high in ACCUM, out_valid only in DONE.
  assign in_hs_c   = in_valid && in_ready;
  assign out_hs_c  = out_valid && out_ready;

  // Frame FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc          <= '0;
      cnt          <= '0;
      len          <= '0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
      out_checksum <= '0;
      out_count    <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok_c) begin
              len      <= frame_len;
              acc      <= '0;
              cnt      <= '0;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              state    <= ACCUM;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (in_hs_c) begin
            acc <= fold_c;
            cnt <= cnt_inc_c;
            if (cnt_inc_c == len) begin
              in_ready     <= 1'b0;
              out_valid    <= 1'b1;
              out_checksum <= fold_c;
              out_count    <= cnt_inc_c;
              state        <= DONE;
            end
          end
        end
        DONE: begin
          // A start seen on this edge is ignored: the engine is not idle yet.
          if (out_hs_c) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_checksum_unit.sv
// Scoreboard bench for xor_checksum_unit: expected checksums/counts are queued
// as frames are issued; a monitor compares and pops on every output handshake.
module tb_xor_checksum_unit;

  localparam int unsigned CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] frame_len;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_checksum;
  logic [CNT_W-1:0] out_count;
  logic             busy;
  logic             err;

  int checks   = 0;
  int failures = 0;

  logic [31:0]      exp_sum_q[$];
  logic [CNT_W-1:0] exp_cnt_q[$];
  logic [31:0]      wbuf[16];

  // Hand-computed expectations that depend on the rotate option.
`ifdef ROTATE_EN
  localparam logic [31:0] EXP_T2 = 32'h0001_F2F3;
  localparam logic [31:0] EXP_T3 = 32'h0000_0002;
  localparam logic [31:0] EXP_T5 = 32'h2B67_A3FF;
  localparam logic [31:0] EXP_T4W = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_T2 = 32'h0000_F0F0;
  localparam logic [31:0] EXP_T3 = 32'h8000_0000;
  localparam logic [31:0] EXP_T5 = 32'h1D3B_5977;
  localparam logic [31:0] EXP_T4W = 32'h0000_000F;
`endif

  xor_checksum_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .frame_len    (frame_len),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_checksum (out_checksum),
    .out_count    (out_count),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: compare presented output against the queue head; pop on handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      checks++;
      if (exp_sum_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output actual=0x%08h count=%0d required=no output",
                 out_checksum, out_count);
      end else begin
        if (out_checksum !== exp_sum_q[0] || out_count !== exp_cnt_q[0]) begin
          failures++;
          $display("FAIL out_checksum actual=0x%08h/%0d required=0x%08h/%0d",
                   out_checksum, out_count, exp_sum_q[0], exp_cnt_q[0]);
        end
        if (out_ready) begin
          void'(exp_sum_q.pop_front());
          void'(exp_cnt_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int n);
    start     = 1'b1;
    frame_len = CNT_W'(n);
    tick();
    start     = 1'b0;
    frame_len = '0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Full frame from wbuf with out_ready held high; returns once idle again.
  task automatic do_frame(input int n, input logic [31:0] exp_sum, input int gap);
    int k;
    exp_sum_q.push_back(exp_sum);
    exp_cnt_q.push_back(CNT_W'(n));
    start_frame(n);
    for (int i = 0; i < n; i++) send_word(wbuf[i], gap);
    chk("out_valid_after_last", 32'(out_valid), 32'd1);
    k = 0;
    while (busy === 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk("idle_after_frame", 32'(busy), 32'd0);
  endtask

  initial begin
    int k;
    rst_n     = 1'b0;
    start     = 1'b0;
    frame_len = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // 1: reset
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_out_checksum", out_checksum, 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);

    // 2: three-word frame
    wbuf[0] = 32'h0000_00FF;
    wbuf[1] = 32'h0000_FF00;
    wbuf[2] = 32'h0000_0F0F;
    do_frame(3, EXP_T2, 0);

    // 3: two-word frame sensitive to rotation
    wbuf[0] = 32'h8000_0001;
    wbuf[1] = 32'h0000_0001;
    do_frame(2, EXP_T3, 0);

    // 4: illegal lengths 0 and 17
    start_frame(0);
    chk("err_len0", 32'(err), 32'd1);
    chk("busy_len0", 32'(busy), 32'd0);
    tick();
    chk("err_len0_clear", 32'(err), 32'd0);
    start_frame(17);
    chk("err_len17", 32'(err), 32'd1);
    chk("busy_len17", 32'(busy), 32'd0);
    tick();
    chk("err_len17_clear", 32'(err), 32'd0);
    chk("in_ready_idle", 32'(in_ready), 32'd0);

    // Four-word frame at full throughput
    wbuf[0] = 32'h1;
    wbuf[1] = 32'h2;
    wbuf[2] = 32'h4;
    wbuf[3] = 32'h8;
    do_frame(4, EXP_T4W, 0);

    // Largest legal frame: 16 all-ones words cancel in both modes
    for (int i = 0; i < 16; i++) wbuf[i] = 32'hFFFF_FFFF;
    do_frame(16, 32'h0, 0);

    // 5: input gaps, start while busy, output back-pressure
    exp_sum_q.push_back(EXP_T5);
    exp_cnt_q.push_back(CNT_W'(2));
    out_ready = 1'b0;
    start_frame(2);
    chk("in_ready_accum", 32'(in_ready), 32'd1);
    start     = 1'b1;
    frame_len = '0;
    tick();
    start     = 1'b0;
    chk("err_start_busy", 32'(err), 32'd0);
    chk("busy_accum", 32'(busy), 32'd1);
    send_word(32'h1234_5678, 3);
    chk("no_out_mid_frame", 32'(out_valid), 32'd0);
    send_word(32'h0F0F_0F0F, 3);
    for (int i = 0; i < 4; i++) begin
      chk("out_valid_held", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("out_valid_drop", 32'(out_valid), 32'd0);
    chk("busy_drop", 32'(busy), 32'd0);

    // Start coincident with output handshake is ignored
    exp_sum_q.push_back(32'hA5A5_A5A5);
    exp_cnt_q.push_back(CNT_W'(1));
    out_ready = 1'b0;
    start_frame(1);
    send_word(32'hA5A5_A5A5, 0);
    chk("out_valid_min", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    start     = 1'b1;
    frame_len = CNT_W'(1);
    tick();
    start     = 1'b0;
    frame_len = '0;
    chk("start_at_done_busy", 32'(busy), 32'd0);
    chk("start_at_done_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("start_at_done_still_idle", 32'(busy), 32'd0);

    // 6: reset mid-frame discards the partial frame
    start_frame(4);
    send_word(32'h1111_1111, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_checksum", out_checksum, 32'd0);
    chk("midrst_out_count", 32'(out_count), 32'd0);
    repeat (3) tick();
    wbuf[0] = 32'hDEAD_BEEF;
    do_frame(1, 32'hDEAD_BEEF, 0);

    // Drain the scoreboard
    k = 0;
    while (exp_sum_q.size() != 0 && k < 100) begin
      tick();
      k++;
    end
    chk("scoreboard_drained", 32'(exp_sum_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
